// File: rtl/btc_sha_hasher.sv
// Fully pipelined double SHA-256 for the second Bitcoin header chunk, one candidate per clock.
// Hash 1 resumes from a round-0 precomputed state; hash 2 hashes the 256-bit hash-1 digest.
module btc_sha_hasher (
   input  logic         CLK,
   input  logic         RST,
   input  logic         write_en,
   input  logic [255:0] digest_intial,
   input  logic [255:0] digest_in,
   input  logic [31:0]  merkle_in,
   input  logic [31:0]  time_in,
   input  logic [31:0]  target_in,
   input  logic [31:0]  nonce_in,
   output logic         valid_out,
   output logic         hit_out,
   output logic [31:0]  time_out,
   output logic [31:0]  nonce_out,
   output logic [255:0] result_out
);

   typedef logic [0:15][31:0] window_t;

   localparam logic [31:0] K [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1,
      32'h923f82a4, 32'hab1c5ed5, 32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
      32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174, 32'he49b69c1, 32'hefbe4786,
      32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147,
      32'h06ca6351, 32'h14292967, 32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
      32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85, 32'ha2bfe8a1, 32'ha81a664b,
      32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a,
      32'h5b9cca4f, 32'h682e6ff3, 32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
      32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   localparam logic [255:0] IV = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                  32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

   function automatic logic [31:0] ror(input logic [31:0] x, input int unsigned n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [255:0] sha_round(input logic [255:0] s, input logic [31:0] k,
                                              input logic [31:0] w);
      logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
      {a, b, c, d, e, f, g, h} = s;
      t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + k + w;
      t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      return {t1 + t2, a, b, c, d + t1, e, f, g};
   endfunction

   // Slide the 16-word schedule window by one, appending the next expanded word.
   function automatic window_t sched_shift(input window_t w);
      window_t r;
      logic [31:0] s0, s1;
      s0 = ror(w[1], 7) ^ ror(w[1], 18) ^ (w[1] >> 3);
      s1 = ror(w[14], 17) ^ ror(w[14], 19) ^ (w[14] >> 10);
      for (int i = 0; i < 15; i++) r[i] = w[i + 1];
      r[15] = s1 + w[9] + s0 + w[0];
      return r;
   endfunction

   function automatic logic [255:0] add8(input logic [255:0] x, input logic [255:0] y);
      logic [255:0] r;
      for (int i = 0; i < 8; i++) r[32*i +: 32] = x[32*i +: 32] + y[32*i +: 32];
      return r;
   endfunction

   logic [31:0]  nonce_counter_reg, time_counter_reg;
   logic [255:0] s1 [64];
   window_t      w1 [63];
   logic [255:0] s2 [64];
   window_t      w2 [63];
   logic [255:0] digest_out_2;
   logic [64:0]  vld1;
   logic [63:0]  vld2;
   logic         valid_out_2;
   logic [31:0]  time_pipe [129];
   logic [31:0]  nonce_pipe [129];
   window_t      msg1, msg2;
   logic [255:0] final_digest, hash_swapped, target, mant_ext;
   logic [31:0]  tgt_c;
   logic [7:0]   tgt_exp;

   assign valid_out_2 = vld1[64];

   always_comb begin
      msg1 = {merkle_in, time_counter_reg, target_in, nonce_counter_reg, 32'h80000000,
              320'h0, 32'h00000280};
      msg2 = {digest_out_2, 32'h80000000, 192'h0, 32'h00000100};
      final_digest = add8(s2[63], IV);
      for (int i = 0; i < 32; i++) hash_swapped[8*i +: 8] = final_digest[255-8*i -: 8];
   end

   // Compact nBits: mantissa scaled by whole bytes, saturating above exponent 32.
   always_comb begin
      tgt_c    = {target_in[7:0], target_in[15:8], target_in[23:16], target_in[31:24]};
      tgt_exp  = tgt_c[31:24];
      mant_ext = {232'h0, tgt_c[23:0]};
      if (tgt_exp > 8'd32)      target = '1;
      else if (tgt_exp >= 8'd3) target = mant_ext << {tgt_exp - 8'd3, 3'b000};
      else                      target = mant_ext >> {8'd3 - tgt_exp, 3'b000};
   end

   // Datapath carries no reset; validity is tracked separately.
   always_ff @(posedge CLK) begin
      s1[0] <= digest_in;
      w1[0] <= sched_shift(msg1);
      for (int i = 1; i < 64; i++) s1[i] <= sha_round(s1[i-1], K[i], w1[i-1][0]);
      for (int i = 1; i < 63; i++) w1[i] <= sched_shift(w1[i-1]);
      digest_out_2 <= add8(s1[63], digest_intial);
      s2[0] <= sha_round(IV, K[0], msg2[0]);
      w2[0] <= sched_shift(msg2);
      for (int i = 1; i < 64; i++) s2[i] <= sha_round(s2[i-1], K[i], w2[i-1][0]);
      for (int i = 1; i < 63; i++) w2[i] <= sched_shift(w2[i-1]);
      time_pipe[0]  <= time_counter_reg;
      nonce_pipe[0] <= nonce_counter_reg;
      for (int i = 1; i < 129; i++) begin
         time_pipe[i]  <= time_pipe[i-1];
         nonce_pipe[i] <= nonce_pipe[i-1];
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         nonce_counter_reg <= nonce_in;
         time_counter_reg  <= time_in;
         vld1       <= '0;
         vld2       <= '0;
         valid_out  <= 1'b0;
         hit_out    <= 1'b0;
         result_out <= '0;
         time_out   <= '0;
         nonce_out  <= '0;
      end else begin
         if (write_en) begin
            nonce_counter_reg <= nonce_counter_reg + 32'd1;
            if (nonce_counter_reg == 32'hFFFFFFFE) time_counter_reg <= time_counter_reg + 32'd1;
         end
         vld1      <= {vld1[63:0], write_en};
         vld2      <= {vld2[62:0], valid_out_2};
         valid_out <= vld2[63];
         hit_out   <= vld2[63] && (hash_swapped <= target);
         if (vld2[63]) begin
            result_out <= final_digest;
            time_out   <= time_pipe[128];
            nonce_out  <= nonce_pipe[128];
         end
      end
   end

endmodule

// File: tb/tb_btc_sha_hasher.sv
// Directed bench for btc_sha_hasher: reference double-SHA-256 model feeding a cycle-stamped
// scoreboard, plus checks of known header vectors, counter wrap, bubbles and mid-stream reset.
module tb_btc_sha_hasher;

   logic         CLK = 1'b0;
   logic         RST = 1'b0;
   logic         write_en = 1'b0;
   logic [255:0] digest_intial = '0;
   logic [255:0] digest_in = '0;
   logic [31:0]  merkle_in = '0, time_in = '0, target_in = '0, nonce_in = '0;
   logic         valid_out, hit_out;
   logic [31:0]  time_out, nonce_out;
   logic [255:0] result_out;

   btc_sha_hasher dut (
      .CLK(CLK), .RST(RST), .write_en(write_en), .digest_intial(digest_intial),
      .digest_in(digest_in), .merkle_in(merkle_in), .time_in(time_in), .target_in(target_in),
      .nonce_in(nonce_in), .valid_out(valid_out), .hit_out(hit_out), .time_out(time_out),
      .nonce_out(nonce_out), .result_out(result_out)
   );

   always #5 CLK = ~CLK;

   localparam logic [31:0] KT [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1,
      32'h923f82a4, 32'hab1c5ed5, 32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
      32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174, 32'he49b69c1, 32'hefbe4786,
      32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147,
      32'h06ca6351, 32'h14292967, 32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
      32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85, 32'ha2bfe8a1, 32'ha81a664b,
      32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a,
      32'h5b9cca4f, 32'h682e6ff3, 32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
      32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };
   localparam logic [255:0] H_IV = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

   typedef struct {
      int unsigned  due;
      logic [31:0]  tm;
      logic [31:0]  nc;
      logic [255:0] res;
      logic         hit;
   } exp_t;

   exp_t        sb[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   int unsigned cyc = 0;
   logic [31:0] time_m = '0, nonce_m = '0;

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      logic [63:0] d;
      d = {x, x} >> n;
      return d[31:0];
   endfunction

   function automatic logic [255:0] compress(input logic [255:0] st, input logic [511:0] blk);
      logic [31:0] w [64];
      logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
      for (int t = 0; t < 16; t++) w[t] = blk[511-32*t -: 32];
      for (int t = 16; t < 64; t++)
         w[t] = (rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7] +
                (rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
      {a, b, c, d, e, f, g, h} = st;
      for (int t = 0; t < 64; t++) begin
         t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + KT[t] + w[t];
         t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
         h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
      end
      return {st[255:224] + a, st[223:192] + b, st[191:160] + c, st[159:128] + d,
              st[127:96] + e, st[95:64] + f, st[63:32] + g, st[31:0] + h};
   endfunction

   function automatic logic [255:0] dsha(input logic [31:0] tm, input logic [31:0] nc);
      logic [255:0] h1;
      h1 = compress(digest_intial, {merkle_in, tm, target_in, nc, 32'h80000000, 320'h0,
                                    32'h00000280});
      return compress(H_IV, {h1, 32'h80000000, 192'h0, 32'h00000100});
   endfunction

   function automatic logic is_hit(input logic [255:0] res, input logic [31:0] nb);
      logic [31:0]  cw;
      logic [255:0] tgt, sw;
      int           ex;
      cw  = {nb[7:0], nb[15:8], nb[23:16], nb[31:24]};
      ex  = int'(cw[31:24]);
      tgt = {232'h0, cw[23:0]};
      for (int i = 3; i < ex; i++) tgt = tgt << 8;
      for (int i = ex; i < 3; i++) tgt = tgt >> 8;
      if (ex > 32) tgt = '1;
      for (int i = 0; i < 32; i++) sw[8*i +: 8] = res[255-8*i -: 8];
      return sw <= tgt;
   endfunction

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   // One clock: push the candidate injected at this edge, then score the outputs.
   task automatic tick();
      exp_t e;
      logic exp_v;
      if (!RST) begin
         sb.delete();
         time_m  = time_in;
         nonce_m = nonce_in;
      end else if (write_en) begin
         e.due = cyc + 130;
         e.tm  = time_m;
         e.nc  = nonce_m;
         e.res = dsha(time_m, nonce_m);
         e.hit = is_hit(e.res, target_in);
         sb.push_back(e);
         if (nonce_m == 32'hFFFFFFFE) time_m = time_m + 32'd1;
         nonce_m = nonce_m + 32'd1;
      end
      @(posedge CLK);
      #1;
      cyc++;
      exp_v = (sb.size() > 0) && (sb[0].due == cyc);
      check("valid_out", 256'(valid_out), 256'(exp_v));
      if (exp_v) begin
         e = sb.pop_front();
         check("sb_result", result_out, e.res);
         check("sb_time", 256'(time_out), 256'(e.tm));
         check("sb_nonce", 256'(nonce_out), 256'(e.nc));
         check("sb_hit", 256'(hit_out), 256'(e.hit));
      end else begin
         check("hit_idle", 256'(hit_out), 256'(0));
      end
   endtask

   initial begin
      digest_intial = {32'hF59007B5, 32'h7A2E5616, 32'hB8F47922, 32'hF4A62AA5,
                       32'hF6F59658, 32'h8185BBAE, 32'hFA09E776, 32'h3BC75771};
      digest_in     = {32'hF7A528B9, 32'hF59007B5, 32'h7A2E5616, 32'hB8F47922,
                       32'hF2C1816D, 32'hF6F59658, 32'h8185BBAE, 32'hFA09E776};
      merkle_in = 32'h252db801;
      target_in = 32'h6461011a;

      // Counter wrap
      time_in  = 32'hAAAAAAA1;
      nonce_in = 32'hFFFFFFF0;
      repeat (2) tick();
      check("rst_valid", 256'(valid_out), 256'(0));
      check("rst_hit", 256'(hit_out), 256'(0));
      check("rst_result", result_out, 256'(0));
      check("rst_time", 256'(time_out), 256'(0));
      check("rst_nonce", 256'(nonce_out), 256'(0));
      check("rst_nonce_cnt", 256'(dut.nonce_counter_reg), 256'(32'hFFFFFFF0));
      RST = 1'b1;
      write_en = 1'b1;
      tick();
      check("wrap_time_1", 256'(dut.time_counter_reg), 256'(32'hAAAAAAA1));
      check("wrap_nonce_1", 256'(dut.nonce_counter_reg), 256'(32'hFFFFFFF1));
      repeat (14) tick();
      check("wrap_nonce_15", 256'(dut.nonce_counter_reg), 256'(32'hFFFFFFFF));
      check("wrap_time_15", 256'(dut.time_counter_reg), 256'(32'hAAAAAAA2));
      tick();
      check("wrap_nonce_16", 256'(dut.nonce_counter_reg), 256'(32'h0));
      check("wrap_time_16", 256'(dut.time_counter_reg), 256'(32'hAAAAAAA2));

      // Reset load with the real header words
      RST = 1'b0;
      write_en = 1'b0;
      time_in  = 32'h130dae51;
      nonce_in = 32'h3aeb9bb0;
      #1;
      check("async_clr_valid", 256'(valid_out), 256'(0));
      repeat (2) tick();
      RST = 1'b1;
      write_en = 1'b1;
      check("load_nonce", 256'(dut.nonce_counter_reg), 256'(32'h3aeb9bb0));
      check("load_valid", 256'(valid_out), 256'(0));
      tick();
      check("load_nonce_1", 256'(dut.nonce_counter_reg), 256'(32'h3aeb9bb1));
      repeat (63) tick();
      check("h1_valid_64", 256'(dut.valid_out_2), 256'(0));
      tick();
      check("h1_valid_65", 256'(dut.valid_out_2), 256'(1));
      check("h1_digest", dut.digest_out_2,
            256'hD113D3BB65EAEED1EBA29A6E06640A8CFD2394C1672229D878D8CEACD8C824A2);
      repeat (65) tick();
      check("e130_valid", 256'(valid_out), 256'(1));
      check("e130_result", result_out,
            256'h4FC234738E7F3AC09F4432A23EAB1E707578A6310F0EB320515D61001CB18E75);
      check("e130_hit", 256'(hit_out), 256'(0));
      check("e130_nonce", 256'(nonce_out), 256'(32'h3aeb9bb0));
      tick();
      check("e131_result", result_out,
            256'hCCA2649D234850E0FD84EDB32B06AE3E415E85F5D19A59622B91F8607B948287);
      repeat (7) tick();
      check("e138_result", result_out,
            256'h5C8AD782C007CC563F8DB735180B35DAB8C983D172B57E2C2701000000000000);
      check("e138_nonce", 256'(nonce_out), 256'(32'h3aeb9bb8));
      check("e138_time", 256'(time_out), 256'(32'h130dae51));
      check("e138_hit", 256'(hit_out), 256'(1));

      // Three-cycle bubble, observed 130 edges later through the scoreboard
      write_en = 1'b0;
      repeat (3) tick();
      write_en = 1'b1;
      repeat (140) tick();

      // Reset mid-stream discards everything in flight
      RST = 1'b0;
      #1;
      check("mid_rst_valid", 256'(valid_out), 256'(0));
      check("mid_rst_result", result_out, 256'(0));
      check("mid_rst_nonce", 256'(nonce_out), 256'(0));
      repeat (2) tick();
      RST = 1'b1;
      repeat (135) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
